// File: rtl/rotfb_pkg.sv
// Shared types and helpers for the rotated triple-buffer frame store.
package rotfb_pkg;
  localparam int NBUF = 3;

  typedef logic [1:0] buf_idx_t;
  typedef enum logic {DIR_CW = 1'b0, DIR_CCW = 1'b1} dir_e;

  // Buffer indices 0,1,2 sum to 3, so the free buffer is whatever remains.
  function automatic buf_idx_t next_wr(input buf_idx_t w, input buf_idx_t r);
    return buf_idx_t'(2'(NBUF) - w - r);
  endfunction

  function automatic logic [31:0] frame_base(input buf_idx_t idx, input int fsz);
    logic [31:0] base;
    case (idx)
      2'd1:    base = 32'(fsz);
      2'd2:    base = 32'(fsz) << 1;
      default: base = '0;
    endcase
    return base;
  endfunction
endpackage

// File: rtl/rotfb_addr_gen.sv
// Writer-side pixel/line counters and incremental rotated write-address generator.
// Addresses step by +/-HEIGHT per pixel and +/-1 per line; no multipliers.
module rotfb_addr_gen
  import rotfb_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 12,
  parameter int AW     = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             hblank,
  input  logic             vblank,
  input  logic [DEPTH-1:0] video_in,
  input  logic             line_end,
  input  logic             frame_end,
  input  logic             ccw,
  input  logic [AW-1:0]    base_nxt,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DEPTH-1:0] wr_data
);
  localparam int FSZ = WIDTH * HEIGHT;
  localparam int XW  = $clog2(WIDTH + 1);
  localparam int YW  = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);
  localparam logic [AW-1:0] STEP  = AW'(HEIGHT);

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  dir_e             dir_q, dir_d;
  logic [AW-1:0]    row_q, row_d;
  logic [AW-1:0]    col_q, col_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DEPTH-1:0] wr_data_q, wr_data_d;
  logic             qual;

  assign qual = ce & ~hblank & ~vblank & (x_q < X_MAX) & (y_q < Y_MAX);

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (frame_end) begin
      // row/col point at pixel (0,0) of the buffer being handed to the writer
      x_d   = '0;
      y_d   = '0;
      dir_d = ccw ? DIR_CCW : DIR_CW;
      row_d = ccw ? base_nxt + AW'(FSZ - HEIGHT) : base_nxt + AW'(HEIGHT - 1);
      col_d = row_d;
    end else if (line_end) begin
      x_d = '0;
      if (y_q < Y_MAX) begin
        y_d   = y_q + YW'(1);
        row_d = (dir_q == DIR_CCW) ? row_q + AW'(1) : row_q - AW'(1);
      end
      col_d = row_d;
    end else if (qual) begin
      wr_en_d   = 1'b1;
      wr_addr_d = col_q;
      wr_data_d = video_in;
      x_d       = x_q + XW'(1);
      col_d     = (dir_q == DIR_CCW) ? col_q - STEP : col_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= DIR_CW;
      row_q     <= AW'(HEIGHT - 1);
      col_q     <= AW'(HEIGHT - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: rtl/rotate_fb_sched.sv
// Triple-buffer ownership scheduler for the 90-degree rotation frame store.
// Optional drop/repeat statistics counters are built when ROTFB_STATS_EN is defined.
module rotate_fb_sched
  import rotfb_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 12,
  localparam int FSZ   = WIDTH * HEIGHT,
  localparam int AW    = $clog2(3 * FSZ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ccw,
  input  logic             ce,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             rd_frame,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DEPTH-1:0] wr_data,
  output logic [1:0]       wr_buf,
  output logic [1:0]       rd_buf,
  output logic [AW-1:0]    rd_base,
  output logic             frame_drop,
  output logic             frame_repeat,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      rep_cnt
);
  logic        blank_q, blank_d;
  logic        vblank_q, vblank_d;
  buf_idx_t    wr_buf_q, wr_buf_d;
  buf_idx_t    rd_buf_q, rd_buf_d;
  buf_idx_t    ready_idx_q, ready_idx_d;
  logic        ready_valid_q, ready_valid_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic        drop_q, drop_d;
  logic        rep_q, rep_d;
  logic        line_end, frame_end;
  buf_idx_t    wr_nxt;
  logic [AW-1:0] base_nxt;

  // Edge history resets high so a blank held through reset is not seen as a new edge.
  assign blank_d   = hblank | vblank;
  assign vblank_d  = vblank;
  assign line_end  = blank_d & ~blank_q;
  assign frame_end = vblank & ~vblank_q;
  assign wr_nxt    = next_wr(wr_buf_q, rd_buf_q);
  assign base_nxt  = AW'(frame_base(wr_nxt, FSZ));

  always_comb begin
    wr_buf_d      = wr_buf_q;
    rd_buf_d      = rd_buf_q;
    ready_idx_d   = ready_idx_q;
    ready_valid_d = ready_valid_q;
    drop_d        = 1'b0;
    rep_d         = 1'b0;
    rd_base_d     = AW'(frame_base(rd_buf_q, FSZ));
    if (frame_end) begin
      // Writer completion wins; a simultaneous reader start takes the fresh frame directly.
      drop_d   = ready_valid_q;
      wr_buf_d = wr_nxt;
      if (rd_frame) begin
        rd_buf_d      = wr_buf_q;
        ready_valid_d = 1'b0;
      end else begin
        ready_idx_d   = wr_buf_q;
        ready_valid_d = 1'b1;
      end
    end else if (rd_frame) begin
      if (ready_valid_q) begin
        rd_buf_d      = ready_idx_q;
        ready_valid_d = 1'b0;
      end else begin
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q       <= 1'b1;
      vblank_q      <= 1'b1;
      wr_buf_q      <= 2'd0;
      rd_buf_q      <= 2'd1;
      ready_idx_q   <= 2'd2;
      ready_valid_q <= 1'b0;
      rd_base_q     <= AW'(FSZ);
      drop_q        <= 1'b0;
      rep_q         <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      vblank_q      <= vblank_d;
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      ready_idx_q   <= ready_idx_d;
      ready_valid_q <= ready_valid_d;
      rd_base_q     <= rd_base_d;
      drop_q        <= drop_d;
      rep_q         <= rep_d;
    end
  end

  rotfb_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .hblank   (hblank),
    .vblank   (vblank),
    .video_in (video_in),
    .line_end (line_end),
    .frame_end(frame_end),
    .ccw      (ccw),
    .base_nxt (base_nxt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

`ifdef ROTFB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;

  // Counters step with the pulse so both become visible on the same cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    if (rep_d && (rep_cnt_q != 16'hFFFF))   rep_cnt_d  = rep_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign rep_cnt  = rep_cnt_q;
`else
  assign drop_cnt = '0;
  assign rep_cnt  = '0;
`endif

  assign wr_buf       = wr_buf_q;
  assign rd_buf       = rd_buf_q;
  assign rd_base      = rd_base_q;
  assign frame_drop   = drop_q;
  assign frame_repeat = rep_q;
endmodule

// File: tb/tb_rotate_fb_sched.sv
// Directed plus randomized bench for rotate_fb_sched against a formula-level reference model.
module tb_rotate_fb_sched;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int D   = 12;
  localparam int FSZ = W * H;
  localparam int AW  = $clog2(3 * FSZ);

  logic          clk = 1'b0;
  logic          reset, ccw, ce, hblank, vblank, rd_frame;
  logic [D-1:0]  video_in;
  logic          wr_en, frame_drop, frame_repeat;
  logic [AW-1:0] wr_addr, rd_base;
  logic [D-1:0]  wr_data;
  logic [1:0]    wr_buf, rd_buf;
  logic [15:0]   drop_cnt, rep_cnt;

  always #5 clk = ~clk;

  rotate_fb_sched #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .ccw(ccw), .ce(ce), .video_in(video_in),
    .hblank(hblank), .vblank(vblank), .rd_frame(rd_frame),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_buf(wr_buf), .rd_buf(rd_buf), .rd_base(rd_base),
    .frame_drop(frame_drop), .frame_repeat(frame_repeat),
    .drop_cnt(drop_cnt), .rep_cnt(rep_cnt)
  );

  int tests = 0;
  int fails = 0;
  bit rnd_rf = 1'b0;
  int got_q[$];
  int cw_tab[12]  = '{2, 5, 8, 11, 1, 4, 7, 10, 0, 3, 6, 9};
  int ccw_tab[12] = '{9, 6, 3, 0, 10, 7, 4, 1, 11, 8, 5, 2};

  // reference model state: frame ownership and writer position in plain integers
  int mx, my, mwr, mrd, mri, dc, rc;
  bit mccw, mrv, pb, pv;
  bit e_en, e_drop, e_rep;
  int e_addr, e_data, e_rdb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model();
    bit le, fe, q;
    int nw;
    if (reset) begin
      mx = 0; my = 0; mccw = 0; mwr = 0; mrd = 1; mri = 2; mrv = 0; pb = 1; pv = 1;
      e_en = 0; e_addr = 0; e_data = 0; e_drop = 0; e_rep = 0; e_rdb = FSZ; dc = 0; rc = 0;
    end else begin
      le = (hblank | vblank) && !pb;
      fe = vblank && !pv;
      q  = ce && !hblank && !vblank && (mx < W) && (my < H);
      e_en = q;
      if (q) begin
        e_addr = mwr * FSZ + (mccw ? (W - 1 - mx) * H + my : mx * H + (H - 1 - my));
        e_data = int'(video_in);
        mx++;
      end
      e_rdb = mrd * FSZ;
      e_drop = 0;
      e_rep = 0;
      if (fe) begin
        e_drop = mrv;
        nw = 3 - mwr - mrd;
        if (rd_frame) begin mrd = mwr; mrv = 0; end
        else begin mri = mwr; mrv = 1; end
        mwr = nw; mx = 0; my = 0; mccw = ccw;
      end else begin
        if (le) begin mx = 0; my++; end
        if (rd_frame) begin
          if (mrv) begin mrd = mri; mrv = 0; end
          else e_rep = 1;
        end
      end
      pb = hblank | vblank;
      pv = vblank;
      if (e_drop && dc < 65535) dc++;
      if (e_rep && rc < 65535) rc++;
    end
  endtask

  task automatic compare();
    check("wr_en", 32'(wr_en), 32'(e_en));
    if (reset || e_en) begin
      check("wr_addr", 32'(wr_addr), e_addr);
      check("wr_data", 32'(wr_data), e_data);
    end
    check("wr_buf", 32'(wr_buf), mwr);
    check("rd_buf", 32'(rd_buf), mrd);
    check("rd_base", 32'(rd_base), e_rdb);
    check("frame_drop", 32'(frame_drop), 32'(e_drop));
    check("frame_repeat", 32'(frame_repeat), 32'(e_rep));
    check("wr_ne_rd", 32'(wr_buf != rd_buf), 1);
`ifdef ROTFB_STATS_EN
    check("drop_cnt", 32'(drop_cnt), dc);
    check("rep_cnt", 32'(rep_cnt), rc);
`else
    check("drop_cnt", 32'(drop_cnt), 0);
    check("rep_cnt", 32'(rep_cnt), 0);
`endif
  endtask

  task automatic cyc(input logic r_i, input logic ce_i, input logic hb_i, input logic vb_i,
                     input logic rf_i);
    reset    = r_i;
    ce       = ce_i;
    hblank   = hb_i;
    vblank   = vb_i;
    rd_frame = rf_i | (rnd_rf && ($urandom_range(0, 11) == 0));
    video_in = D'($urandom);
    @(posedge clk);
    #1;
    model();
    compare();
    if (wr_en === 1'b1) got_q.push_back(int'(wr_addr));
  endtask

  task automatic send_lines(input int nl, input int np, input bit gaps);
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < np; p++) begin
        if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
      end
      cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0);
      cyc(0, 1'($urandom_range(0, 1)), 1, 0, 0);
    end
  endtask

  initial begin
    ccw = 0; ce = 0; hblank = 0; vblank = 0; rd_frame = 0; video_in = '0; reset = 1;

    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_wr_buf", 32'(wr_buf), 0);
    check("rst_rd_buf", 32'(rd_buf), 1);
    check("rst_rd_base", 32'(rd_base), 12);
    check("rst_wr_en", 32'(wr_en), 0);

    // reader restart with nothing ready
    cyc(0, 0, 0, 0, 1);
    check("rep_pulse", 32'(frame_repeat), 1);
    check("rep_rd_buf", 32'(rd_buf), 1);
    check("rep_rd_base", 32'(rd_base), 12);
    cyc(0, 0, 0, 0, 0);

    // cw frame into buffer 0
    got_q.delete();
    send_lines(3, 4, 0);
    check("cw_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size()) check("cw_addr", got_q[i], cw_tab[i]);
    ccw = 1;
    cyc(0, 0, 1, 1, 0);
    check("f1_wr_buf", 32'(wr_buf), 2);
    check("f1_drop", 32'(frame_drop), 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // ccw frame into buffer 2; second completion drops the unread frame
    got_q.delete();
    send_lines(3, 4, 0);
    check("ccw_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got_q.size()) check("ccw_addr", got_q[i], ccw_tab[i] + 24);
    ccw = 0;
    cyc(0, 0, 1, 1, 0);
    check("f2_drop", 32'(frame_drop), 1);
    check("f2_wr_buf", 32'(wr_buf), 0);
`ifdef ROTFB_STATS_EN
    check("f2_drop_cnt", 32'(drop_cnt), 1);
`else
    check("f2_drop_cnt", 32'(drop_cnt), 0);
`endif
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1);
    check("take_rd_buf", 32'(rd_buf), 2);
    cyc(0, 0, 0, 0, 0);
    check("take_rd_base", 32'(rd_base), 24);

    // simultaneous frame end and reader start from reset ownership
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1);
    check("sim_rd_buf", 32'(rd_buf), 0);
    check("sim_wr_buf", 32'(wr_buf), 2);
    check("sim_drop", 32'(frame_drop), 0);
    check("sim_rep", 32'(frame_repeat), 0);
    cyc(0, 0, 1, 1, 0);
    check("sim_rd_base", 32'(rd_base), 0);
    cyc(0, 0, 0, 0, 1);
    check("sim_not_ready", 32'(frame_repeat), 1);

    // reset in the middle of a line
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("mid_wr_en", 32'(wr_en), 0);
    check("mid_wr_addr", 32'(wr_addr), 0);
    check("mid_wr_buf", 32'(wr_buf), 0);
    check("mid_rd_base", 32'(rd_base), 12);
    cyc(0, 1, 0, 0, 0);
    check("mid_first_en", 32'(wr_en), 1);
    check("mid_first_addr", 32'(wr_addr), H - 1);

    // randomized frames: odd sizes, ce gaps, random reader starts and resets
    rnd_rf = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_lines(1, 2, 1);
        cyc(1, 1, 0, 0, 0);
      end
      send_lines($urandom_range(1, 4), $urandom_range(1, 6), 1);
      ccw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) cyc(0, 0, 1'($urandom_range(0, 1)), 1, 0);
    end
    rnd_rf = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
